// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared state enum and default parameters for the PLL lock detector
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACQ    = 2'd2,
    ST_LOCKED = 2'd3
  } pll_state_e;

  localparam int N_DEF          = 32;
  localparam int TOL_DEF        = 1;
  localparam int LOCK_CNT_DEF   = 16;
  localparam int UNLOCK_CNT_DEF = 2;
  localparam int CW_DEF         = 16;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic pclk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_detect.sv
// rtl/pll_lock_detect.sv - refclk period measurement in pclk cycles with lock/unlock hysteresis
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic               pclk,
  input  logic               resetn,
  input  logic               refclk,
  input  logic               enable,
  output logic               locked,
  output logic [CW-1:0]      meas,
  output logic               meas_valid,
  output logic signed [CW:0] freq_err,
  output logic               lock_lost
);

  localparam int              GW        = cnt_width(LOCK_CNT);
  localparam int              BW        = cnt_width(UNLOCK_CNT);
  localparam logic [CW-1:0]   CNT_MAX   = '1;
  localparam logic [GW-1:0]   GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0]   BAD_LAST  = BW'(UNLOCK_CNT - 1);
  localparam logic [CW:0]     N_EXT     = (CW+1)'(N);
  localparam logic [CW:0]     TOL_EXT   = (CW+1)'(TOL);

  if (LOCK_CNT < 1 || UNLOCK_CNT < 1 ||
      longint'(N) + longint'(TOL) >= (longint'(1) << CW) - 1) begin : g_bad_params
    $error("pll_lock_detect: illegal LOCK_CNT/UNLOCK_CNT/N/TOL/CW combination");
  end

  logic            ref_sync;
  logic            ref_prev_q;
  logic            ref_edge;
  pll_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
  logic [CW-1:0]   meas_q, meas_d;
  logic [CW:0]     freq_err_q, freq_err_d;
  logic            meas_valid_q, meas_valid_d;
  logic            locked_q, locked_d;
  logic            lock_lost_q, lock_lost_d;
  logic            measuring;
  logic            capture;
  logic            saturated;
  logic            good;
  logic [CW:0]     err_abs;

  sync_2ff u_sync_2ff (
    .pclk  (pclk),
    .resetn(resetn),
    .d_i   (refclk),
    .q_o   (ref_sync)
  );

  assign ref_edge  = ref_sync & ~ref_prev_q;
  assign measuring = (state_q == ST_ACQ) || (state_q == ST_LOCKED);
  assign capture   = enable && measuring && ref_edge;
  assign saturated = (cnt_q == CNT_MAX);
  assign err_abs   = freq_err_q[CW] ? ((CW+1)'(0) - freq_err_q) : freq_err_q;
  assign good      = (err_abs <= TOL_EXT);

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      ref_prev_q   <= 1'b0;
      cnt_q        <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      meas_q       <= '0;
      freq_err_q   <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_prev_q   <= ref_sync;
      cnt_q        <= cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      meas_q       <= meas_d;
      freq_err_q   <= freq_err_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;

    if (!enable || state_q == ST_IDLE) cnt_d = '0;
    else if (ref_edge)                 cnt_d = CW'(1);
    else if (!saturated)               cnt_d = cnt_q + CW'(1);

    if (!enable) begin
      state_d    = ST_IDLE;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM:  if (ref_edge) state_d = ST_ACQ;
        ST_ACQ: begin
          // A stopped refclk drops back to ARM; a coincident edge is measured instead.
          if (saturated && !ref_edge) begin
            state_d    = ST_ARM;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else if (meas_valid_q) begin
            if (!good) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == GOOD_LAST) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (saturated && !ref_edge) begin
            state_d    = ST_ARM;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else if (meas_valid_q) begin
            if (good) begin
              bad_cnt_d = '0;
            end else if (bad_cnt_q == BAD_LAST) begin
              state_d    = ST_ACQ;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    meas_d       = meas_q;
    freq_err_d   = freq_err_q;
    meas_valid_d = 1'b0;
    if (capture) begin
      meas_d       = cnt_q;
      freq_err_d   = {1'b0, cnt_q} - N_EXT;
      meas_valid_d = 1'b1;
    end
    locked_d    = (state_d == ST_LOCKED);
    lock_lost_d = enable && (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
  end

  assign locked     = locked_q;
  assign meas       = meas_q;
  assign meas_valid = meas_valid_q;
  assign freq_err   = $signed(freq_err_q);
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// tb/tb_pll_lock_detect.sv - randomized self-checking bench for pll_lock_detect
module tb_pll_lock_detect;

  localparam int N          = 32;
  localparam int TOL        = 1;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 2;
  localparam int CW         = 16;
  localparam int CNT_MAX    = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_ARM = 1, M_ACQ = 2, M_LOCKED = 3;

  logic               pclk = 1'b0;
  logic               resetn;
  logic               refclk;
  logic               enable;
  logic               locked;
  logic [CW-1:0]      meas;
  logic               meas_valid;
  logic signed [CW:0] freq_err;
  logic               lock_lost;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  int     lost_seen = 0;
  int     obs_meas[$];
  int     obs_ferr[$];
  bit     obs_lock[$];
  int     exp_meas[$];
  bit     exp_lock[$];
  int     m_state, m_good, m_bad, m_lost;
  longint m_last_rise;

  pll_lock_detect #(
    .N(N), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CW(CW)
  ) dut (
    .pclk      (pclk),
    .resetn    (resetn),
    .refclk    (refclk),
    .enable    (enable),
    .locked    (locked),
    .meas      (meas),
    .meas_valid(meas_valid),
    .freq_err  (freq_err),
    .lock_lost (lock_lost)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (meas_valid) begin
      obs_meas.push_back(int'(meas));
      obs_ferr.push_back(int'(freq_err));
      obs_lock.push_back(locked);
    end
    if (lock_lost) lost_seen <= lost_seen + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Reference behaviour at refclk-edge granularity: interval lengths in pclk cycles.
  function automatic void model_gap(input longint now);
    if ((m_state == M_ACQ || m_state == M_LOCKED) && now - m_last_rise >= CNT_MAX) begin
      if (m_state == M_LOCKED) m_lost++;
      m_state = M_ARM;
      m_good  = 0;
      m_bad   = 0;
    end
  endfunction

  function automatic void model_rise(input longint now);
    longint gap;
    bit     ok;
    gap = now - m_last_rise;
    if (gap > CNT_MAX) model_gap(now);
    m_last_rise = now;
    if (m_state == M_ARM) begin
      m_state = M_ACQ;
    end else if (m_state == M_ACQ || m_state == M_LOCKED) begin
      exp_meas.push_back(int'(gap));
      exp_lock.push_back(m_state == M_LOCKED);
      ok = (gap >= N - TOL) && (gap <= N + TOL);
      if (m_state == M_ACQ) begin
        m_good = ok ? m_good + 1 : 0;
        if (m_good == LOCK_CNT) begin m_state = M_LOCKED; m_good = 0; m_bad = 0; end
      end else begin
        m_bad = ok ? 0 : m_bad + 1;
        if (m_bad == UNLOCK_CNT) begin m_state = M_ACQ; m_good = 0; m_bad = 0; m_lost++; end
      end
    end
  endfunction

  task automatic drive_period(input int p);
    refclk = 1'b1;
    model_rise(cyc);
    repeat (p / 2) @(negedge pclk);
    refclk = 1'b0;
    repeat (p - p / 2) @(negedge pclk);
  endtask

  task automatic set_enable(input bit v);
    enable = v;
    if (!v) begin m_state = M_IDLE; m_good = 0; m_bad = 0; end
    else if (m_state == M_IDLE) m_state = M_ARM;
    repeat (4) @(negedge pclk);
  endtask

  task automatic restart();
    set_enable(1'b0);
    set_enable(1'b1);
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; refclk = 1'b0;
    m_state = M_IDLE; m_good = 0; m_bad = 0; m_lost = 0; m_last_rise = 0;
    repeat (3) @(negedge pclk);
    n_vec++;
    if ({locked, meas_valid, lock_lost} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: locked/meas_valid/lock_lost=%b, expected 000", {locked, meas_valid, lock_lost});
    end
    n_vec++;
    if (meas !== '0 || freq_err !== '0) begin
      n_err++; $display("FAIL reset_data: meas=%0d freq_err=%0d, expected 0 0", meas, freq_err);
    end
    resetn = 1'b1;
    repeat (2) @(negedge pclk);
    for (int i = 0; i < 4; i++) drive_period(int'($urandom_range(28, 36)));
    n_vec++;
    if (obs_meas.size() != 0 || locked !== 1'b0) begin
      n_err++; $display("FAIL idle_no_meas: pulses=%0d locked=%b, expected 0 0", obs_meas.size(), locked);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_lock_acquire();
    restart();
    for (int i = 0; i < 5; i++) drive_period(N);
    n_vec++;
    if (obs_meas.size() != LOCK_CNT || exp_meas.size() != LOCK_CNT) begin
      n_err++; $display("FAIL acquire_count: pulses=%0d model=%0d, expected %0d", obs_meas.size(), exp_meas.size(), LOCK_CNT);
    end
    while (obs_meas.size() > 0 && exp_meas.size() > 0) begin
      int om, of, em; bit ol, el;
      om = obs_meas.pop_front(); of = obs_ferr.pop_front(); ol = obs_lock.pop_front();
      em = exp_meas.pop_front(); el = exp_lock.pop_front();
      n_vec++;
      if (om != em || of != em - N || ol != el) begin
        n_err++; $display("FAIL acquire_meas: meas=%0d freq_err=%0d locked=%0b, expected %0d %0d %0b", om, of, ol, em, em - N, el);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || m_state != M_LOCKED) begin
      n_err++; $display("FAIL acquire_locked: locked=%b, expected 1", locked);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_off_freq();
    restart();
    for (int i = 0; i < 6; i++) drive_period(N + 2);
    n_vec++;
    if (obs_meas.size() != exp_meas.size() || obs_meas.size() != 5) begin
      n_err++; $display("FAIL offfreq_count: pulses=%0d, expected 5", obs_meas.size());
    end
    while (obs_meas.size() > 0 && exp_meas.size() > 0) begin
      int om, of, em; bit ol, el;
      om = obs_meas.pop_front(); of = obs_ferr.pop_front(); ol = obs_lock.pop_front();
      em = exp_meas.pop_front(); el = exp_lock.pop_front();
      n_vec++;
      if (om != 34 || of != 2 || om != em || ol != el) begin
        n_err++; $display("FAIL offfreq_meas: meas=%0d freq_err=%0d locked=%0b, expected 34 2 %0b", om, of, ol, el);
      end
    end
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL offfreq_locked: locked=%b, expected 0", locked);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_unlock();
    restart();
    for (int i = 0; i < 5; i++) drive_period(N);
    drive_period(N - 2);
    drive_period(N - 2);
    drive_period(N);
    while (obs_meas.size() > 0 && exp_meas.size() > 0) begin
      int om, of, em; bit ol, el;
      om = obs_meas.pop_front(); of = obs_ferr.pop_front(); ol = obs_lock.pop_front();
      em = exp_meas.pop_front(); el = exp_lock.pop_front();
      n_vec++;
      if (om != em || of != em - N || ol != el) begin
        n_err++; $display("FAIL unlock_meas: meas=%0d freq_err=%0d locked=%0b, expected %0d %0d %0b", om, of, ol, em, em - N, el);
      end
    end
    n_vec++;
    if (obs_meas.size() != exp_meas.size()) begin
      n_err++; $display("FAIL unlock_count: leftover pulses=%0d, expected %0d", obs_meas.size(), exp_meas.size());
    end
    n_vec++;
    if (locked !== 1'b0 || lost_seen != m_lost) begin
      n_err++; $display("FAIL unlock_drop: locked=%b lock_lost pulses=%0d, expected 0 %0d", locked, lost_seen, m_lost);
    end
    // From ACQ (not ARM) four good intervals relock without a discarded edge.
    for (int i = 0; i < LOCK_CNT; i++) drive_period(N);
    n_vec++;
    if (locked !== 1'b1 || m_state != M_LOCKED) begin
      n_err++; $display("FAIL unlock_relock: locked=%b, expected 1", locked);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_jitter_random();
    int bad_at;
    restart();
    for (int i = 0; i < 5; i++) drive_period(N);
    bad_at = int'($urandom_range(2, 12));
    for (int i = 0; i < 16; i++) begin
      if (i == bad_at) drive_period(N + 3);
      else             drive_period(N - 1 + int'($urandom_range(0, 2)));
    end
    while (obs_meas.size() > 0 && exp_meas.size() > 0) begin
      int om, of, em; bit ol, el;
      om = obs_meas.pop_front(); of = obs_ferr.pop_front(); ol = obs_lock.pop_front();
      em = exp_meas.pop_front(); el = exp_lock.pop_front();
      n_vec++;
      if (om != em || of != em - N || ol != el) begin
        n_err++; $display("FAIL jitter_meas: meas=%0d freq_err=%0d locked=%0b, expected %0d %0d %0b", om, of, ol, em, em - N, el);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || lost_seen != m_lost || obs_meas.size() != exp_meas.size()) begin
      n_err++; $display("FAIL jitter_hold: locked=%b lock_lost pulses=%0d, expected 1 %0d", locked, lost_seen, m_lost);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_random_periods();
    restart();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) drive_period(N - 4 + int'($urandom_range(0, 8)));
      else                           drive_period(N - 1 + int'($urandom_range(0, 2)));
    end
    while (obs_meas.size() > 0 && exp_meas.size() > 0) begin
      int om, of, em; bit ol, el;
      om = obs_meas.pop_front(); of = obs_ferr.pop_front(); ol = obs_lock.pop_front();
      em = exp_meas.pop_front(); el = exp_lock.pop_front();
      n_vec++;
      if (om != em || of != em - N || ol != el) begin
        n_err++; $display("FAIL random_meas: meas=%0d freq_err=%0d locked=%0b, expected %0d %0d %0b", om, of, ol, em, em - N, el);
      end
    end
    n_vec++;
    if (locked !== (m_state == M_LOCKED) || lost_seen != m_lost || obs_meas.size() != exp_meas.size()) begin
      n_err++; $display("FAIL random_state: locked=%b lock_lost pulses=%0d, expected %0b %0d", locked, lost_seen, m_state == M_LOCKED, m_lost);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_saturate();
    restart();
    for (int i = 0; i < 5; i++) drive_period(N);
    obs_meas.delete(); obs_ferr.delete(); obs_lock.delete(); exp_meas.delete(); exp_lock.delete();
    repeat (CNT_MAX + 100) @(negedge pclk);
    model_gap(cyc);
    n_vec++;
    if (locked !== 1'b0 || lost_seen != m_lost || m_state != M_ARM) begin
      n_err++; $display("FAIL saturate_drop: locked=%b lock_lost pulses=%0d, expected 0 %0d", locked, lost_seen, m_lost);
    end
    n_vec++;
    if (obs_meas.size() != 0) begin
      n_err++; $display("FAIL saturate_nomeas: pulses=%0d, expected 0", obs_meas.size());
    end
    for (int i = 0; i < 1 + LOCK_CNT; i++) drive_period(N);
    n_vec++;
    if (locked !== 1'b1 || obs_meas.size() != LOCK_CNT || exp_meas.size() != LOCK_CNT) begin
      n_err++; $display("FAIL saturate_relock: locked=%b pulses=%0d, expected 1 %0d", locked, obs_meas.size(), LOCK_CNT);
    end
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
  endtask

  task automatic test_reset_mid_lock();
    int lost_before;
    restart();
    for (int i = 0; i < 5; i++) drive_period(N);
    exp_meas.delete(); exp_lock.delete(); obs_meas.delete(); obs_ferr.delete(); obs_lock.delete();
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: locked=%b, expected 1", locked);
    end
    repeat (10) @(negedge pclk);
    lost_before = lost_seen;
    #2;
    resetn = 1'b0;
    enable = 1'b0;
    m_state = M_IDLE; m_good = 0; m_bad = 0;
    #1;
    n_vec++;
    if ({locked, meas_valid, lock_lost} !== 3'b000 || meas !== '0 || freq_err !== '0) begin
      n_err++; $display("FAIL midreset_async: locked=%b mv=%b lost=%b meas=%0d ferr=%0d, expected all 0", locked, meas_valid, lock_lost, meas, freq_err);
    end
    repeat (3) @(negedge pclk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) drive_period(N);
    n_vec++;
    if (locked !== 1'b0 || obs_meas.size() != 0 || lost_seen != lost_before) begin
      n_err++; $display("FAIL midreset_idle: locked=%b pulses=%0d lock_lost pulses=%0d, expected 0 0 %0d", locked, obs_meas.size(), lost_seen - lost_before, 0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    refclk = 1'b0;
    @(negedge pclk);
    test_reset();
    test_lock_acquire();
    test_off_freq();
    test_unlock();
    test_jitter_random();
    test_random_periods();
    test_saturate();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_detect.md
PLL_LOCK_DETECT -- requirements
Module: pll_lock_detect

Interface
REQ-001 Parameter N, default 32, expected pclk cycles per refclk period (feedback divide ratio).
REQ-002 Parameter TOL, default 1, maximum |measured - N| counted as a good measurement.
REQ-003 Parameter LOCK_CNT, default 16, consecutive good measurements required to assert lock.
REQ-004 Parameter UNLOCK_CNT, default 2, consecutive bad measurements that drop lock.
REQ-005 Parameter CW, default 16, counter/measurement width.
REQ-006 pclk  in  1  DCO output clock; sole clock of the block.
REQ-007 resetn  in  1  asynchronous, active-low reset.
REQ-008 refclk  in  1  reference clock, asynchronous to pclk, sampled as data.
REQ-009 enable  in  1  measurement enable, synchronous to pclk.
REQ-010 locked  out  1  lock indication.
REQ-011 meas  out  CW  last completed refclk period in pclk cycles.
REQ-012 meas_valid  out  1  one-cycle pulse when meas updates.
REQ-013 freq_err  out  CW+1 signed  meas - N, updated with meas.
REQ-014 lock_lost  out  1  one-cycle pulse on LOCKED exit other than by enable or reset.

Function
REQ-015 refclk shall pass a 2-flop synchronizer, then a third flop; ref_edge = sync & ~prev, one pclk cycle per refclk rising edge.
REQ-016 Running counter cnt shall increment each pclk cycle, saturating at 2^CW-1; on ref_edge it loads 1.
REQ-017 On ref_edge in ACQ or LOCKED, meas <= cnt and freq_err <= cnt - N (signed, CW+1 bits), with meas_valid high in the following cycle; interval of exactly N pclk cycles yields meas = N.
REQ-018 good = |freq_err| <= TOL, evaluated on the meas_valid cycle only.
REQ-019 FSM states: IDLE, ARM, ACQ, LOCKED.
REQ-020 IDLE: enable=1 -> ARM; cnt held at 0.
REQ-021 ARM: first ref_edge -> ACQ; partial interval discarded, no meas_valid.
REQ-022 ACQ: good increments good_cnt; good_cnt reaching LOCK_CNT -> LOCKED; bad clears good_cnt.
REQ-023 LOCKED: bad increments bad_cnt; bad_cnt reaching UNLOCK_CNT -> ACQ, good_cnt=0, lock_lost pulse; good clears bad_cnt.
REQ-024 cnt saturation in ACQ or LOCKED (refclk stopped) -> ARM, counters cleared; lock_lost pulses if leaving LOCKED.
REQ-025 enable=0 in any state -> IDLE next cycle, counters cleared, no lock_lost; enable has priority over ref_edge.
REQ-026 locked shall be a registered decode of state == LOCKED, high the cycle after the LOCKED transition.
REQ-027 Saturation and ref_edge in the same cycle: ref_edge wins, meas = 2^CW-1 (bad).
REQ-028 Parameter legality: LOCK_CNT>=1, UNLOCK_CNT>=1, N+TOL < 2^CW-1; elaboration error otherwise.

Reset
REQ-029 resetn low shall asynchronously force state IDLE, synchronizer flops 0, cnt/good_cnt/bad_cnt 0.
REQ-030 Reset outputs: locked 0, meas 0, meas_valid 0, freq_err 0, lock_lost 0.
REQ-031 Reset mid-LOCKED: locked falls asynchronously, no lock_lost pulse; after release, ARM is re-entered only via enable.

Structure
REQ-032 Shared package pll_pkg shall hold the state enum and default constants (N, TOL, LOCK_CNT, UNLOCK_CNT, CW).
REQ-033 Synchronizer shall be sub-module sync_2ff (async-reset, resetn, reset value 0); the remainder is flat.

Verification (N=32, TOL=1, LOCK_CNT=4, UNLOCK_CNT=2, CW=16)
REQ-034 refclk period = 32 pclk, enable=1 -> first edge discarded, meas=32, freq_err=0 on 4 pulses, locked rises after the 4th.
REQ-035 refclk period = 34 pclk -> meas=34, freq_err=+2 every pulse, locked stays 0.
REQ-036 Locked, then two periods of 30 -> freq_err=-2 twice, lock_lost one pulse, locked falls, state ACQ.
REQ-037 Locked, refclk held low -> cnt saturates at 65535 -> lock_lost pulse, locked 0, state ARM; restart refclk at 32 -> relock after 1+4 edges.
REQ-038 Locked, resetn pulsed low mid-interval -> all outputs 0 immediately, no lock_lost; enable low -> stays IDLE.
REQ-039 Alternating 32/33/31 periods -> all good, lock holds; single 35 period while LOCKED -> locked stays 1, bad_cnt clears on next good.
